// File: rtl/alu_r32i.sv
// Single-cycle RV32I/M integer ALU. Operation is decoded combinationally from
// ALUCode and the result is registered, giving exactly one cycle of latency.
package alu_r32i_pkg;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_CPY    = 5'd10,
    ALU_MUL    = 5'd11,
    ALU_MULH   = 5'd12,
    ALU_MULHSU = 5'd13,
    ALU_MULHU  = 5'd14
  } alu_code_e;

endpackage

module alu_r32i
  import alu_r32i_pkg::*;
#(
  parameter int dataW = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [dataW-1:0] A,
  input  logic [dataW-1:0] B,
  input  logic [4:0]       ALUCode,
  output logic [dataW-1:0] result
);

  localparam int ShW = $clog2(dataW);

  logic [ShW-1:0]     shamt;
  logic               mul_a_signed;
  logic               mul_b_signed;
  logic [2*dataW-1:0] mul_a;
  logic [2*dataW-1:0] mul_b;
  logic [2*dataW-1:0] product;
  logic [dataW-1:0]   next_result;

  // Upper operand bits beyond the shift width are deliberately ignored.
  assign shamt = B[ShW-1:0];

  // One shared multiplier: each variant only differs in how the operands
  // are extended to double width before an unsigned multiply.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch is never inferred.
    mul_a_signed = 1'b0;
    mul_b_signed = 1'b0;
    case (ALUCode)
      ALU_MULH: begin
        mul_a_signed = 1'b1;
        mul_b_signed = 1'b1;
      end
      ALU_MULHSU: mul_a_signed = 1'b1;
      default: ;
    endcase
  end

  assign mul_a   = {{dataW{mul_a_signed & A[dataW-1]}}, A};
  assign mul_b   = {{dataW{mul_b_signed & B[dataW-1]}}, B};
  assign product = mul_a * mul_b;

  always_comb begin
    next_result = '0;
    case (ALUCode)
      ALU_ADD:    next_result = A + B;
      ALU_SUB:    next_result = A - B;
      ALU_SLL:    next_result = A << shamt;
      ALU_SLT:    next_result = {{(dataW-1){1'b0}}, $signed(A) < $signed(B)};
      ALU_SLTU:   next_result = {{(dataW-1){1'b0}}, A < B};
      ALU_XOR:    next_result = A ^ B;
      ALU_SRL:    next_result = A >> shamt;
      ALU_SRA:    next_result = $unsigned($signed(A) >>> shamt);
      ALU_OR:     next_result = A | B;
      ALU_AND:    next_result = A & B;
      ALU_CPY:    next_result = B;
      ALU_MUL:    next_result = product[dataW-1:0];
      ALU_MULH,
      ALU_MULHSU,
      ALU_MULHU:  next_result = product[2*dataW-1:dataW];
      default:    next_result = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples its inputs as they were before the edge.
    if (reset) result <= '0;
    else       result <= next_result;
  end

endmodule

// File: tb/tb_alu_r32i.sv
// Self-checking bench for alu_r32i: directed vectors plus randomized traffic
// against an arithmetic reference model, checked through a scoreboard queue.
module tb_alu_r32i;

  logic        clock;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  ALUCode;
  logic [31:0] result;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t scoreboard[$];
  int   checks = 0;
  int   errors = 0;

  alu_r32i #(.dataW(32)) dut (
    .clock   (clock),
    .reset   (reset),
    .A       (A),
    .B       (B),
    .ALUCode (ALUCode),
    .result  (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: derived from the arithmetic meaning of each operation.
  function automatic logic [31:0] ref_model(input int code, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    int              s  = int'(b & 32'd31);
    longint          p2 = longint'(1) << s;
    logic [63:0]     p;
    p = '0;
    case (code)
      0:  p = ua + ub;
      1:  p = ua - ub;
      2:  p = ua * 64'(p2);
      3:  p = (sa < sb) ? 64'd1 : 64'd0;
      4:  p = (ua < ub) ? 64'd1 : 64'd0;
      5:  p = ua ^ ub;
      6:  p = ua / 64'(p2);
      7:  p = (sa - ((sa < 0) ? (p2 - 1) : 0)) / p2;
      8:  p = ua | ub;
      9:  p = ua & ub;
      10: p = ub;
      11: p = sa * sb;
      12: begin p = sa * sb;          return p[63:32]; end
      13: begin p = sa * longint'(ub); return p[63:32]; end
      14: begin p = ua * ub;          return p[63:32]; end
      default: p = '0;
    endcase
    return p[31:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and record what must appear after the edge.
  task automatic drive(input string name, input logic rst, input int code,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    exp_t e;
    @(negedge clock);
    reset   = rst;
    ALUCode = 5'(code);
    A       = a;
    B       = b;
    e.name  = name;
    e.exp   = exp;
    scoreboard.push_back(e);
  endtask

  // Monitor: the result is valid every cycle, sampled just after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (scoreboard.size() != 0) begin
        e = scoreboard.pop_front();
        check(e.name, result, e.exp);
      end
    end
  end

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int          code;
    logic        rst;

    reset = 1'b1; A = '0; B = '0; ALUCode = '0;
    drive("reset_state", 1, 0, 32'd9, 32'd4, 32'd0);
    drive("reset_hold",  1, 11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);

    drive("add_9_4",        0, 0,  32'd9, 32'd4, 32'd13);
    drive("slt_9_4",        0, 3,  32'd9, 32'd4, 32'd0);
    drive("sltu_9_4",       0, 4,  32'd9, 32'd4, 32'd0);
    drive("sub_9_4",        0, 1,  32'd9, 32'd4, 32'd5);
    drive("sub_9_10",       0, 1,  32'd9, 32'd10, 32'hFFFF_FFFF);
    drive("slt_2_4",        0, 3,  32'd2, 32'd4, 32'd1);
    drive("sltu_m2_4",      0, 4,  -32'sd2, 32'd4, 32'd0);
    drive("sltu_m2_m1",     0, 4,  -32'sd2, -32'sd1, 32'd1);
    drive("slt_m2_m1",      0, 3,  -32'sd2, -32'sd1, 32'd1);
    drive("and_9_5",        0, 9,  32'd9, 32'd5, 32'd1);
    drive("or_9_5",         0, 8,  32'd9, 32'd5, 32'd13);
    drive("xor_9_5",        0, 5,  32'd9, 32'd5, 32'd12);
    drive("sll_9_1",        0, 2,  32'd9, 32'd1, 32'd18);
    drive("srl_9_3",        0, 6,  32'd9, 32'd3, 32'd1);
    drive("sra_9_3",        0, 7,  32'd9, 32'd3, 32'd1);
    drive("sra_m9_3",       0, 7,  -32'sd9, 32'd3, 32'hFFFF_FFFE);
    drive("srl_m9_3",       0, 6,  -32'sd9, 32'd3, 32'h1FFF_FFFE);
    drive("cpy_3",          0, 10, -32'sd9, 32'd3, 32'd3);
    drive("sll_shamt0",     0, 2,  32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF);
    drive("mul_2_4",        0, 11, 32'd2, 32'd4, 32'd8);
    drive("mul_2_m4",       0, 11, 32'd2, -32'sd4, 32'hFFFF_FFF8);
    drive("mulh_2_m4",      0, 12, 32'd2, -32'sd4, 32'hFFFF_FFFF);
    drive("mulhu_2_m4",     0, 14, 32'd2, -32'sd4, 32'd1);
    drive("mulhsu_2_m4",    0, 13, 32'd2, -32'sd4, 32'd1);
    drive("mulhsu_m1_m1",   0, 13, -32'sd1, -32'sd1, 32'hFFFF_FFFF);
    drive("add_before_rst", 0, 0,  32'd100, 32'd23, 32'd123);
    drive("rst_midstream",  1, 0,  32'd100, 32'd23, 32'd0);
    drive("add_after_rst",  0, 0,  32'd100, 32'd23, 32'd123);
    drive("sub_m78_m901",   0, 1,  -32'sd78, -32'sd901, 32'd823);
    drive("code_20",        0, 20, 32'd9, 32'd4, 32'd0);
    drive("code_15",        0, 15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    drive("code_31",        0, 31, 32'hFFFF_FFFF, 32'h1, 32'd0);
    drive("sll_1_0x21",     0, 2,  32'd1, 32'h21, 32'd2);

    for (int i = 0; i < 2000; i++) begin
      a    = pick_operand();
      b    = pick_operand();
      code = ($urandom_range(0, 9) == 0) ? int'($urandom_range(15, 31))
                                         : int'($urandom_range(0, 14));
      rst  = ($urandom_range(0, 31) == 0);
      drive($sformatf("rand%0d_op%0d", i, code), rst, code, a, b,
            rst ? 32'd0 : ref_model(code, a, b));
    end

    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    checks++;
    if (scoreboard.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries expected 0", scoreboard.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_r32i.md
ALU_R32I -- requirements
Module: alu_r32i

Interface
REQ-001 SHALL have parameter dataW, default 32, operand and result width in bits; all values in this document are given for dataW=32.
REQ-002 SHALL have port clock, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have port A, input, dataW bits, first operand (rs1), two's-complement.
REQ-005 SHALL have port B, input, dataW bits, second operand (rs2 or immediate), two's-complement.
REQ-006 SHALL have port ALUCode, input, 5 bits, operation select per REQ-009.
REQ-007 SHALL have port result, output, dataW bits, registered operation result.

Function
REQ-008 SHALL compute the operation combinationally from A, B and ALUCode, and register it into result on each rising clock edge when reset=0; latency is exactly 1 cycle, with a new operation accepted every cycle.
REQ-009 SHALL decode ALUCode as follows, with codes defined in the shared ALU code header: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, CPY=10, MUL=11, MULH=12, MULHSU=13, MULHU=14.
REQ-010 SHALL drive result to 0 for any ALUCode value from 15 to 31.
REQ-011 ADD/SUB SHALL compute A+B and A-B modulo 2^dataW; overflow wraps and no flags are produced.
REQ-012 SLT SHALL produce 1 if A<B as signed values and 0 otherwise, zero-extended to dataW bits.
REQ-013 SLTU SHALL produce 1 if A<B as unsigned values and 0 otherwise, zero-extended to dataW bits.
REQ-014 AND/OR/XOR SHALL operate bitwise on A and B.
REQ-015 SLL/SRL/SRA SHALL shift A by B[4:0] and ignore B[31:5]: SLL fills with zeros, SRL is logical, SRA replicates A[31]; a shift amount of 0 returns A unchanged.
REQ-016 CPY SHALL pass B through unchanged (LUI path).
REQ-017 MUL SHALL return bits [31:0] of the 64-bit product A*B; these bits are identical for signed and unsigned operands.
REQ-018 MULH SHALL return bits [63:32] of the product with A signed and B signed.
REQ-019 MULHSU SHALL return bits [63:32] of the product with A signed and B unsigned.
REQ-020 MULHU SHALL return bits [63:32] of the product with A unsigned and B unsigned.
REQ-021 SHALL have no internal state besides the result register; the output depends only on A, B and ALUCode sampled at the previous edge.

Reset
REQ-022 When reset=1 at a rising clock edge, result SHALL become 0, regardless of the values of A, B and ALUCode.
REQ-023 At the first edge where reset=0, result SHALL take the value computed from the inputs present at that edge; no extra recovery cycle is inserted.
REQ-024 Until the first edge at which reset is asserted, the value of result is undefined (X in simulation is acceptable).

Verification
REQ-025 A=9, B=4: ADD -> 13; SLT -> 0; SLTU -> 0; SUB -> 5; with B=10, SUB -> 0xFFFFFFFF (-1), each observed one cycle after the inputs are applied.
REQ-026 Compare ops: A=2, B=4, SLT -> 1; A=-2, B=4, SLTU -> 0; A=-2, B=-1, SLTU -> 1 and SLT -> 1.
REQ-027 Logic/shift ops: A=9, B=5: AND -> 1, OR -> 13, XOR -> 12. A=9, B=1, SLL -> 18. A=9, B=3: SRL -> 1, SRA -> 1. A=-9, B=3: SRA -> 0xFFFFFFFE, SRL -> 0x1FFFFFFE, CPY -> 3.
REQ-028 Multiply ops: A=2, B=4, MUL -> 8. A=2, B=-4: MUL -> 0xFFFFFFF8, MULH -> 0xFFFFFFFF, MULHU -> 1, MULHSU -> 1.
REQ-029 Reset and edge cases: reset asserted mid-stream with ADD active -> result=0 at the next edge and ADD result at the first edge after release; A=-78, B=-901, SUB -> 823; ALUCode=20 -> 0; A=1, B=0x21, SLL -> 2 (only B[4:0] is used).
